simon_round_scheduler: RTL and testbench
========================================

# simon_round_scheduler

Shares one iterative SIMON datapath (`SIMON_round` plus `SIMON_keyexpansion`) between `P` requesters. Arbitration between requesters is round-robin. For each accepted request, the block:

- expands the key into a round-key store,
- runs `T` encrypt or decrypt rounds,
- returns the result over a valid/ready output.

An optional key cache skips expansion when the key matches the last one expanded. The block sits between the system request ports and the cipher core, and is the only sequencer of that core.

## Interface
- `N`, 16: word width in bits; block width is 2N.
- `M`, 4: key words.
- `T`, 32: rounds.
- `C`, 5: round counter width; must satisfy 2^C ≥ T.
- `P`, 2: number of requesters.
- `clk` in 1: the only clock. Everything samples on posedge.
- `R` in 1: synchronous, active-high reset, sampled on posedge `clk`.
- `req` in P: per-port request level.
- `enc_dec` in P: per-port mode; 1 = encrypt, 0 = decrypt.
- `block` in P×2N: per-port input block `{x,y}`.
- `key` in P×M×N: per-port key; `key[i][M-1]` is the most significant word.
- `gnt` out P: one-cycle acceptance pulse, one-hot.
- `outValid` out 1: result available.
- `outReady` in 1: consumer accepts the result.
- `outData` out 2N: result block.
- `outPort` out $clog2(P): index of the port that owns the result.
- `busy` out 1: high in every state except `IDLE`.

## Operation
- States:
  - `IDLE`
  - `KEXP`: key expansion, T cycles.
  - `CRYPT`: T cycles.
  - `DONE`: result held until accepted.
- **`IDLE`**
  - If any `req` is high, grant the first requesting port at or after (`rrPtr`+1) mod P.
  - Capture that port's `block`, `key` and `enc_dec`, and its index into `outPort`.
  - Set `rrPtr` to the granted index and pulse `gnt` in the following cycle.
  - Go to `KEXP`, or to `CRYPT` on a cache hit.
- **`KEXP`**, for `count` = 0..T-1:
  - `rk[count]` ← `pKeys[0]`.
  - `pKeys` ← `{oKey, pKeys[M-1:1]}`, where `oKey` comes from `SIMON_keyexpansion` driven with `count`.
  - After `count` = T-1: set `cacheValid` and `cacheKey`, reset `count` to 0, go to `CRYPT`.
- **`CRYPT`**, for `count` = 0..T-1:
  - Encrypt: `p` ← round(`p`, `rk[count]`).
  - Decrypt: `p` is loaded half-swapped (`{y,x}`) on entry, each round uses `rk[T-1-count]`, and the output is swapped back on exit to `DONE`.
  - After `count` = T-1: drive `outData` and set `outValid`, go to `DONE`.
- **`DONE`**
  - `outValid`, `outData` and `outPort` stay constant.
  - On an edge where `outReady` = 1: `outValid` ← 0, go to `IDLE`.
  - A new grant can never be issued in the same cycle that `DONE` exits.
- **Requester rules**
  - Hold `req` and the data stable until `gnt` is seen.
  - Dropping `req` before grant withdraws the request.
  - `req` while the block is busy is ignored and stays pending.
- **Cache hit:** `cacheValid` && (captured key == `cacheKey`) && `SIMON_KEY_CACHE_EN`. Mode does not matter; the same `rk` store serves both directions.
- **Reset:**
  - `state` = `IDLE`, `gnt` = 0, `outValid` = 0, `outData` = 0, `outPort` = 0, `busy` = 0.
  - `rrPtr` = P-1, so port 0 wins first.
  - `cacheValid` = 0, `count` = 0.
  - Reset mid-operation aborts the operation with no result and invalidates the cache. Partial `rk` contents are never reused.

## Timing
- Capture edge E0 in `IDLE`; `gnt` is high for the cycle after E0 only.
- Miss: `KEXP` edges E1..ET, `CRYPT` edges ET+1..E2T. `outValid` rises after E2T, i.e. 2T+1 edges after capture (65 at defaults).
- Hit: `CRYPT` edges E1..ET. `outValid` rises after ET, i.e. T+1 edges after capture (33 at defaults).
- `DONE` → `IDLE` takes 1 edge after `outReady`. The earliest next capture is the edge after that.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SIMON_KEY_CACHE_EN` defined:
  - `cacheKey` (M×N) and `cacheValid` are instantiated.
  - A matching key skips `KEXP`.
- Undefined:
  - No cache registers; every request runs `KEXP`.
  - Latency is always 2T+1.
  - All other behaviour is identical.

## Structure
- `simon_pkg` holds:
  - the state enum typedef;
  - default values of N, M, T, C;
  - SIMON32/64 test-vector constants shared with the bench.
- Sub-module `simon_rr_arbiter`: takes `req`, `rrPtr` and enable; produces a one-hot grant and its index. Purely combinational.
- The scheduler instantiates the existing `SIMON_round` and `SIMON_keyexpansion` and owns the `rk[T]` store.

## Test plan
1. **Single encrypt, cold cache.**
   - Stimulus: reset; port 0 encrypt, `key` = 1918_1110_0908_0100, `block` = 6565_6877, `outReady` = 1.
   - Expect: `gnt` = 01 for one cycle; `outValid` after 65 edges with `outData` = c69b_e9bb, `outPort` = 0.
2. **Decrypt with cache hit.**
   - Stimulus: then port 1 decrypt, same key, `block` = c69b_e9bb.
   - Expect: `outData` = 6565_6877, `outPort` = 1, latency 33 with the macro defined, 65 without.
3. **Round-robin fairness.**
   - Stimulus: both ports hold `req` from reset.
   - Expect: grants go 0, 1, 0, 1; never the same port twice while the other is waiting.
4. **Output backpressure.**
   - Stimulus: `outReady` = 0 for 10 cycles in `DONE` while `req` is pending.
   - Expect: `outValid`, `outData` and `outPort` stay stable; no `gnt`; grant comes 2 edges after `outReady` rises.
5. **Reset mid-operation.**
   - Stimulus: assert `R` during `CRYPT` (count = 10), release, re-request the same key.
   - Expect: `outValid` = 0 and `busy` = 0 after the reset edge; the re-request takes the full 65-edge path (cache invalidated).
6. **Key change forces a miss.**
   - Stimulus: after test 1, encrypt with `key` = 0000_0000_0000_0001.
   - Expect: `KEXP` is re-run (65 edges); a following request with the 1918… key also misses.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: FSM state type, default SIMON32/64 geometry and reference vectors
// shared by the round scheduler and its bench.
package simon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      KEXP  = 2'd1,
      CRYPT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SIMON_N = 16;
   localparam int SIMON_M = 4;
   localparam int SIMON_T = 32;
   localparam int SIMON_C = 5;

   // z0 constant sequence; bit j holds z0_j (the published string read left to right).
   localparam logic [61:0] SIMON_Z0 =
      62'b01100111000011010100100010111110110011100001101010010001011111;

   localparam logic [63:0] SIMON_TV_KEY = 64'h1918_1110_0908_0100;
   localparam logic [31:0] SIMON_TV_PT  = 32'h6565_6877;
   localparam logic [31:0] SIMON_TV_CT  = 32'hc69b_e9bb;

endpackage

// File: rtl/simon_round_scheduler_if.sv
// simon_round_scheduler_if: request ports and result channel of the SIMON round scheduler.
// req is a level held until gnt (a one-cycle pulse); a result moves on a posedge where
// outValid and outReady are both high, and outValid/outData/outPort hold until then.
interface simon_round_scheduler_if
   import simon_pkg::*;
#(
   parameter int N = SIMON_N,
   parameter int M = SIMON_M,
   parameter int P = 2
);
   localparam int PW = (P > 1) ? $clog2(P) : 1;

   logic [P-1:0]                req;
   logic [P-1:0]                enc_dec;
   logic [P-1:0][2*N-1:0]       block;
   logic [P-1:0][M-1:0][N-1:0]  key;
   logic [P-1:0]                gnt;
   logic                        outValid;
   logic                        outReady;
   logic [2*N-1:0]              outData;
   logic [PW-1:0]               outPort;
   logic                        busy;

   modport master (
      output req, enc_dec, block, key, outReady,
      input  gnt, outValid, outData, outPort, busy
   );

   modport slave (
      input  req, enc_dec, block, key, outReady,
      output gnt, outValid, outData, outPort, busy
   );
endinterface

// File: rtl/SIMON_keyexpansion.sv
// SIMON_keyexpansion: next key word k[i] from k[i-1], k[i-3], k[i-m] and the z0 bit
// selected by count (= i - m); z0 is the SIMON32/64 sequence.
module SIMON_keyexpansion
   import simon_pkg::*;
#(
   parameter int N = SIMON_N,
   parameter int M = SIMON_M,
   parameter int C = SIMON_C
) (
   input  logic [N-1:0] k_prev,
   input  logic [N-1:0] k_m3,
   input  logic [N-1:0] k_m,
   input  logic [C-1:0] count,
   output logic [N-1:0] oKey
);

   logic [N-1:0] t0, t1;
   logic [5:0]   zi;

   if (M == 4) begin : g_m4
      assign t0 = {k_prev[2:0], k_prev[N-1:3]} ^ k_m3;
   end else begin : g_mx
      assign t0 = {k_prev[2:0], k_prev[N-1:3]};
   end

   assign t1   = t0 ^ {t0[0], t0[N-1:1]};
   assign zi   = 6'(int'(count) % 62);
   assign oKey = ~k_m ^ t1 ^ N'(3) ^ {{(N-1){1'b0}}, SIMON_Z0[zi]};

endmodule

// File: rtl/SIMON_round.sv
// SIMON_round: one Feistel round, {x,y} -> {y ^ f(x) ^ rk, x}.
module SIMON_round #(
   parameter int N = 16
) (
   input  logic [2*N-1:0] blk_in,
   input  logic [N-1:0]   rk,
   output logic [2*N-1:0] blk_out
);

   logic [N-1:0] x, y, fx;

   assign x  = blk_in[2*N-1:N];
   assign y  = blk_in[N-1:0];
   // f(x) = (x <<< 1 & x <<< 8) ^ (x <<< 2)
   assign fx = ({x[N-2:0], x[N-1]} & {x[N-9:0], x[N-1:N-8]}) ^ {x[N-3:0], x[N-1:N-2]};
   assign blk_out = {y ^ fx ^ rk, x};

endmodule

// File: rtl/simon_rr_arbiter.sv
// simon_rr_arbiter: combinational round-robin pick of the first requesting port at or
// after (rr_ptr + 1) mod P; produces a one-hot grant and its index.
module simon_rr_arbiter #(
   parameter int P  = 2,
   parameter int PW = 1
) (
   input  logic          en,
   input  logic [P-1:0]  req,
   input  logic [PW-1:0] rr_ptr,
   output logic [P-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_any
);

   always_comb begin
      logic [PW-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int k = 1; k <= P; k++) begin
         idx = PW'((int'(rr_ptr) + k) % P);
         if (en && !gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/simon_round_scheduler.sv
// simon_round_scheduler: shares one iterative SIMON core between P round-robin ports.
// Define SIMON_KEY_CACHE_EN to skip key expansion when the key matches the last one.
module simon_round_scheduler
   import simon_pkg::*;
#(
   parameter int N = SIMON_N,
   parameter int M = SIMON_M,
   parameter int T = SIMON_T,
   parameter int C = SIMON_C,
   parameter int P = 2
) (
   input  logic                    clk,
   input  logic                    R,
   simon_round_scheduler_if.slave  bus,
   output state_t                  dbg_state
);

   localparam int PW = (P > 1) ? $clog2(P) : 1;

   state_t              state, state_nx;
   logic [C-1:0]        count;
   logic [PW-1:0]       rr_ptr;
   logic [P-1:0]        arb_gnt;
   logic [PW-1:0]       arb_idx;
   logic                arb_any;
   logic                capture, last, cache_hit;
   logic [2*N-1:0]      sel_block;
   logic [M-1:0][N-1:0] sel_key;
   logic [M-1:0][N-1:0] p_keys;
   logic [N-1:0]        rk [T];
   logic [2*N-1:0]      p, round_out;
   logic [N-1:0]        o_key, round_key;
   logic                mode_enc;

   simon_rr_arbiter #(.P(P), .PW(PW)) u_arb (
      .en      (state == IDLE),
      .req     (bus.req),
      .rr_ptr  (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   assign sel_block = bus.block[arb_idx];
   assign sel_key   = bus.key[arb_idx];
   assign last      = (count == C'(T - 1));
   assign dbg_state = state;

`ifdef SIMON_KEY_CACHE_EN
   logic                cache_valid;
   logic [M-1:0][N-1:0] cache_key;

   assign cache_hit = cache_valid && (sel_key == cache_key);

   // The key is latched at capture; it only becomes usable once all T round keys exist.
   always_ff @(posedge clk) begin
      if (R) begin
         cache_valid <= 1'b0;
      end else if (capture && !cache_hit) begin
         cache_valid <= 1'b0;
         cache_key   <= sel_key;
      end else if (state == KEXP && last) begin
         cache_valid <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (R) state <= IDLE;
      else   state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               capture  = 1'b1;
               state_nx = cache_hit ? CRYPT : KEXP;
            end
         end
         KEXP:    if (last) state_nx = CRYPT;
         CRYPT:   if (last) state_nx = DONE;
         DONE:    if (bus.outReady) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Decrypt runs the forward round on the half-swapped block with round keys reversed.
   assign round_key = mode_enc ? rk[count] : rk[C'(T - 1) - count];

   SIMON_round #(.N(N)) u_round (
      .blk_in  (p),
      .rk      (round_key),
      .blk_out (round_out)
   );

   SIMON_keyexpansion #(.N(N), .M(M), .C(C)) u_kexp (
      .k_prev (p_keys[M-1]),
      .k_m3   (p_keys[1]),
      .k_m    (p_keys[0]),
      .count  (count),
      .oKey   (o_key)
   );

   always_ff @(posedge clk) begin
      if (R) begin
         count        <= '0;
         rr_ptr       <= PW'(P - 1);
         bus.gnt      <= '0;
         bus.outValid <= 1'b0;
         bus.outData  <= '0;
         bus.outPort  <= '0;
         bus.busy     <= 1'b0;
      end else begin
         bus.gnt  <= capture ? arb_gnt : '0;
         bus.busy <= (state_nx != IDLE);
         if (capture) begin
            rr_ptr      <= arb_idx;
            bus.outPort <= arb_idx;
            count       <= '0;
         end else if (state == KEXP || state == CRYPT) begin
            count <= last ? '0 : count + 1'b1;
         end
         if (state == CRYPT && last) begin
            bus.outValid <= 1'b1;
            bus.outData  <= mode_enc ? round_out : {round_out[N-1:0], round_out[2*N-1:N]};
         end else if (state == DONE && bus.outReady) begin
            bus.outValid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         mode_enc <= bus.enc_dec[arb_idx];
         p        <= bus.enc_dec[arb_idx] ? sel_block : {sel_block[N-1:0], sel_block[2*N-1:N]};
         p_keys   <= sel_key;
      end else if (state == KEXP) begin
         rk[count] <= p_keys[0];
         p_keys    <= {o_key, p_keys[M-1:1]};
      end else if (state == CRYPT) begin
         p <= round_out;
      end
   end

endmodule

// File: tb/tb_simon_round_scheduler.sv
// tb_simon_round_scheduler: directed and randomized checks of the round scheduler against
// a word-level SIMON32/64 model and a key-cache/round-robin model.
module tb_simon_round_scheduler;
   import simon_pkg::*;

   localparam int T = SIMON_T;

   logic   clk = 1'b0;
   logic   R;
   state_t dbg_state;

   simon_round_scheduler_if #(.N(SIMON_N), .M(SIMON_M), .P(2)) bus ();

   simon_round_scheduler #(
      .N(SIMON_N), .M(SIMON_M), .T(SIMON_T), .C(SIMON_C), .P(2)
   ) dut (
      .clk       (clk),
      .R         (R),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int          m_rr;
   bit          m_cvalid;
   logic [63:0] m_ckey;
   logic [63:0] r_key [2];
   logic [31:0] r_blk [2];
   bit          r_enc [2];
   logic [63:0] pool  [2];

   function automatic logic [15:0] ror(input logic [15:0] x, input int s);
      return (x >> s) | (x << (16 - s));
   endfunction

   function automatic logic [15:0] rol(input logic [15:0] x, input int s);
      return (x << s) | (x >> (16 - s));
   endfunction

   function automatic logic [31:0] simon_ref(input logic [63:0] key, input logic [31:0] blk,
                                             input bit enc);
      string       z0 = "11111010001001010110000111001101111101000100101011000011100110";
      logic [15:0] k [32];
      logic [15:0] x, y, tmp, f;
      for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
      for (int i = 4; i < 32; i++) begin
         tmp  = ror(k[i-1], 3) ^ k[i-3];
         tmp  = tmp ^ ror(tmp, 1);
         k[i] = ~k[i-4] ^ tmp ^ 16'(z0[i-4] == "1") ^ 16'd3;
      end
      x = blk[31:16];
      y = blk[15:0];
      if (enc) begin
         for (int i = 0; i < 32; i++) begin
            f   = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
            tmp = x;
            x   = y ^ f ^ k[i];
            y   = tmp;
         end
      end else begin
         for (int i = 31; i >= 0; i--) begin
            f   = (rol(y, 1) & rol(y, 8)) ^ rol(y, 2);
            tmp = y;
            y   = x ^ f ^ k[i];
            x   = tmp;
         end
      end
      return {x, y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_port(input int p, input bit en, input logic [31:0] blk,
                             input logic [63:0] k);
      r_key[p]         = k;
      r_blk[p]         = blk;
      r_enc[p]         = en;
      bus.key[p]       = k;
      bus.block[p]     = blk;
      bus.enc_dec[p]   = en;
      bus.req[p]       = 1'b1;
   endtask

   task automatic wait_grant(input int exp_port);
      int w = 0;
      do begin
         tick();
         w++;
      end while (bus.gnt == '0 && w < 400);
      check($sformatf("gnt_p%0d", exp_port), 64'(bus.gnt), 64'(1) << exp_port);
      m_rr = exp_port;
   endtask

   task automatic collect(input int p);
      int          lat  = 1;
      bit          seen = 1'b0;
      int          exp_lat;
      logic [63:0] k    = r_key[p];
`ifdef SIMON_KEY_CACHE_EN
      exp_lat = (m_cvalid && m_ckey == k) ? T + 1 : 2 * T + 1;
`else
      exp_lat = 2 * T + 1;
`endif
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         lat++;
         if (i == 0) check("gnt_pulse_width", 64'(bus.gnt), 64'd0);
         seen = bus.outValid;
      end
      check($sformatf("latency_p%0d", p), 64'(lat), 64'(exp_lat));
      check($sformatf("outData_p%0d", p), 64'(bus.outData), 64'(simon_ref(k, r_blk[p], r_enc[p])));
      check("outPort", 64'(bus.outPort), 64'(p));
      m_cvalid = 1'b1;
      m_ckey   = k;
   endtask

   task automatic accept();
      bus.outReady = 1'b1;
      tick();
      check("outValid_after_accept", 64'(bus.outValid), 64'd0);
      check("busy_after_accept", 64'(bus.busy), 64'd0);
   endtask

   task automatic apply_reset();
      R = 1'b1;
      tick();
      check("rst_outValid", 64'(bus.outValid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      R        = 1'b0;
      m_rr     = 1;
      m_cvalid = 1'b0;
   endtask

   initial begin
      int w;
      R            = 1'b1;
      bus.req      = '0;
      bus.enc_dec  = '0;
      bus.block    = '0;
      bus.key      = '0;
      bus.outReady = 1'b0;
      m_rr         = 1;
      m_cvalid     = 1'b0;
      m_ckey       = '0;
      pool[0]      = SIMON_TV_KEY;
      pool[1]      = {$urandom, $urandom};
      repeat (2) tick();
      check("rst_outData", 64'(bus.outData), 64'd0);
      check("rst_outPort", 64'(bus.outPort), 64'd0);
      apply_reset();
      bus.outReady = 1'b1;

      // single encrypt on a cold cache, then decrypt of the result on port 1
      drive_port(0, 1'b1, SIMON_TV_PT, SIMON_TV_KEY);
      wait_grant(0);
      bus.req[0] = 1'b0;
      collect(0);
      check("tv_ciphertext", 64'(bus.outData), 64'(SIMON_TV_CT));
      accept();
      drive_port(1, 1'b0, SIMON_TV_CT, SIMON_TV_KEY);
      wait_grant(1);
      bus.req[1] = 1'b0;
      collect(1);
      check("tv_plaintext", 64'(bus.outData), 64'(SIMON_TV_PT));
      accept();

      // key change forces a miss, and the old key misses again afterwards
      drive_port(0, 1'b1, $urandom, 64'h0000_0000_0000_0001);
      wait_grant(1 - m_rr);
      bus.req[0] = 1'b0;
      collect(0);
      accept();
      drive_port(1, 1'b1, $urandom, SIMON_TV_KEY);
      wait_grant(1);
      bus.req[1] = 1'b0;
      collect(1);
      accept();

      // output backpressure with another request pending
      bus.outReady = 1'b0;
      drive_port(0, 1'b1, $urandom, SIMON_TV_KEY);
      wait_grant(0);
      bus.req[0] = 1'b0;
      collect(0);
      drive_port(1, 1'b0, $urandom, {$urandom, $urandom});
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_outValid", 64'(bus.outValid), 64'd1);
         check("bp_outData", 64'(bus.outData), 64'(simon_ref(r_key[0], r_blk[0], r_enc[0])));
         check("bp_outPort", 64'(bus.outPort), 64'd0);
         check("bp_no_gnt", 64'(bus.gnt), 64'd0);
      end
      bus.outReady = 1'b1;
      tick();
      check("bp_exit_no_gnt", 64'(bus.gnt), 64'd0);
      check("bp_exit_outValid", 64'(bus.outValid), 64'd0);
      tick();
      check("bp_gnt_two_edges", 64'(bus.gnt), 64'b10);
      m_rr = 1;
      bus.req[1] = 1'b0;
      collect(1);
      accept();

      // reset in the middle of CRYPT, then the same key must re-expand
      drive_port(0, 1'b1, $urandom, SIMON_TV_KEY);
      wait_grant(0);
      bus.req[0] = 1'b0;
      w = 0;
      while (dbg_state != CRYPT && w < 100) begin
         tick();
         w++;
      end
      check("mid_in_crypt", 64'(dbg_state), 64'(CRYPT));
      repeat (10) tick();
      apply_reset();
      drive_port(0, 1'b1, $urandom, SIMON_TV_KEY);
      wait_grant(0);
      bus.req[0] = 1'b0;
      collect(0);
      accept();

      // round-robin fairness with both ports requesting from reset
      R = 1'b1;
      drive_port(0, 1'b1, $urandom, {$urandom, $urandom});
      drive_port(1, 1'b1, $urandom, {$urandom, $urandom});
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         wait_grant(i % 2);
         collect(i % 2);
         accept();
      end
      bus.req = '0;
      tick();

      // randomized requests with a small key pool and random consumer stalls
      for (int it = 0; it < 8; it++) begin
         int mask, cand, ep;
         bus.outReady = 1'b0;
         mask = $urandom_range(1, 3);
         for (int p = 0; p < 2; p++)
            if (mask[p]) drive_port(p, 1'($urandom_range(0, 1)), $urandom, pool[$urandom_range(0, 1)]);
         cand = (m_rr + 1) % 2;
         ep   = mask[cand] ? cand : 1 - cand;
         wait_grant(ep);
         bus.req = '0;
         collect(ep);
         repeat ($urandom_range(0, 3)) begin
            tick();
            check("rand_hold_outValid", 64'(bus.outValid), 64'd1);
         end
         accept();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
